// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: bubble encoding, default
// reset PC and the fetch FSM state encoding.
package if_pkg;

    localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_pc_gen.sv
// PC register with +4 adder and redirect mux. With IF_DELAY_SLOT_EN defined, a
// redirect is parked in a pending register and applied on the delay slot's handoff.
module if_pc_gen
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    input  logic        advance_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] pc_next_o
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] target_w;

    assign target_w = target_i & ALIGN_MASK;
    assign pc_plus4 = pc_q + 32'd4;

`ifdef IF_DELAY_SLOT_EN
    logic [31:0] pend_q;
    logic [31:0] pend_d;
    logic        pend_valid_q;
    logic        pend_valid_d;

    // The slot's handoff consumes the redirect; a redirect arriving with the
    // handoff itself goes straight to the PC.
    always_comb begin
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (advance_i) begin
            pend_valid_d = 1'b0;
            if (redirect_i)        pc_d = target_w;
            else if (pend_valid_q) pc_d = pend_q;
            else                   pc_d = pc_plus4;
        end else if (redirect_i) begin
            pend_d       = target_w;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC & ALIGN_MASK;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end
`else
    always_comb begin
        pc_d = pc_q;
        if (redirect_i)     pc_d = target_w;
        else if (advance_i) pc_d = pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC & ALIGN_MASK;
        else       pc_q <= pc_d;
    end
`endif

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4;
    assign pc_next_o  = pc_d;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: FETCH/WAIT/HOLD fetch FSM, hold register and kill logic.
// Define IF_DELAY_SLOT_EN for MIPS delay-slot behaviour (no wrong-path kill).
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_ID_Write,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    output logic        IM_Req,
    output logic [31:0] IM_Addr,
    input  logic        IM_Ready,
    input  logic        IM_Rvalid,
    input  logic [31:0] IM_Rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_Instruction,
    output logic        IF_Valid,
    output logic [1:0]  dbg_state_o
);

    fetch_state_e state_q;
    logic         discard_q;
    logic [31:0]  instr_q;
    logic [31:0]  if_pc_q;

    logic         kill;
    logic         handoff;
    logic         accept;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  pc_next;

`ifdef IF_DELAY_SLOT_EN
    assign kill = 1'b0;
`else
    assign kill = Branch_Taken;
`endif

    // The next request is issued in the handoff cycle itself, which is what
    // gives one instruction every two cycles on a zero-wait memory.
    assign handoff  = !reset && (state_q == HOLD) && IF_ID_Write && !kill;
    assign IM_Req   = !reset && !kill && ((state_q == FETCH) || handoff);
    assign IM_Addr  = handoff ? pc_next : pc;
    assign accept   = IM_Req && IM_Ready;

    assign IF_Valid       = !reset && (state_q == HOLD) && !kill;
    assign IF_Instruction = IF_Valid ? instr_q : NOP_INSTR;
    assign IF_PC          = IF_Valid ? if_pc_q : 32'h0;
    assign dbg_state_o    = state_q;

    if_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk        (clk),
        .reset      (reset),
        .redirect_i (Branch_Taken),
        .target_i   (Branch_Target),
        .advance_i  (handoff),
        .pc_o       (pc),
        .pc_plus4_o (pc_plus4),
        .pc_next_o  (pc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            discard_q <= 1'b0;
            instr_q   <= NOP_INSTR;
            if_pc_q   <= '0;
        end else if (kill) begin
            // A redirect mid-flight must swallow the stale response; if it is
            // already arriving this cycle it is simply not latched.
            if (state_q == WAIT && !IM_Rvalid) begin
                discard_q <= 1'b1;
            end else begin
                state_q   <= FETCH;
                discard_q <= 1'b0;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (accept) state_q <= WAIT;
                end
                WAIT: begin
                    if (IM_Rvalid) begin
                        if (discard_q) begin
                            discard_q <= 1'b0;
                            state_q   <= FETCH;
                        end else begin
                            instr_q <= IM_Rdata;
                            if_pc_q <= pc_plus4;
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (handoff) state_q <= accept ? WAIT : FETCH;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

endmodule
